// File: rtl/sd_cmd_sequencer_if.sv
// Byte-engine handshake between the SD command sequencer (master) and the SPI byte shifter (slave).
interface sd_cmd_sequencer_if;
    logic       BYTE_SEND;
    logic [7:0] BYTE_OUT;
    logic       BYTE_BUSY;
    logic [7:0] BYTE_IN;

    modport master (output BYTE_SEND, BYTE_OUT, input  BYTE_BUSY, BYTE_IN);
    modport slave  (input  BYTE_SEND, BYTE_OUT, output BYTE_BUSY, BYTE_IN);
endinterface

// File: rtl/sd_cmd_sequencer.sv
// One SD SPI command transaction per START: 0xFF preamble, 6-byte frame, R1 poll with timeout.
// Owns chip select so software does not have to bracket the byte writes itself.
module sd_cmd_sequencer #(
    parameter int PRE_BYTES     = 1,
    parameter int TIMEOUT_BYTES = 8
) (
    input  logic               CLOCK_24,
    input  logic               RESET,
    input  logic               START,
    input  logic               ABORT,
    input  logic               CS_RELEASE,
    input  logic [5:0]         CMD_INDEX,
    input  logic [31:0]        CMD_ARG,
    input  logic [6:0]         CMD_CRC,
    input  logic               KEEP_CS,
    sd_cmd_sequencer_if.master spi,
    output logic               SPI_CS_N,
    output logic               BUSY,
    output logic               DONE,
    output logic [7:0]         RESP,
    output logic               TIMEOUT
);
    typedef enum logic [2:0] {S_IDLE, S_PRE, S_FRAME, S_POLL, S_FIN} state_t;
    typedef enum logic [1:0] {P_ISSUE, P_ARM, P_WAIT} phase_t;

    typedef struct packed {
        logic [5:0]  index;
        logic [31:0] arg;
        logic [6:0]  crc;
        logic        keep_cs;
    } cmd_t;

    localparam logic [2:0] PRE_LAST  = 3'(PRE_BYTES - 1);
    localparam logic [7:0] POLL_LAST = 8'(TIMEOUT_BYTES - 1);

    state_t     state;
    phase_t     phase;
    cmd_t       cmd;
    cmd_t       cmd_in;
    logic [2:0] byte_cnt;
    logic [7:0] poll_cnt;

    assign cmd_in = {CMD_INDEX, CMD_ARG, CMD_CRC, KEEP_CS};

    function automatic logic [7:0] frame_byte(input cmd_t c, input logic [2:0] idx);
        logic [7:0] b;
        case (idx)
            3'd0:    b = {2'b01, c.index};
            3'd1:    b = c.arg[31:24];
            3'd2:    b = c.arg[23:16];
            3'd3:    b = c.arg[15:8];
            3'd4:    b = c.arg[7:0];
            default: b = {c.crc, 1'b1};
        endcase
        return b;
    endfunction

    always_ff @(posedge CLOCK_24) begin
        if (RESET) begin
            state         <= S_IDLE;
            phase         <= P_ISSUE;
            cmd           <= '0;
            byte_cnt      <= '0;
            poll_cnt      <= '0;
            spi.BYTE_SEND <= 1'b0;
            spi.BYTE_OUT  <= 8'hFF;
            SPI_CS_N      <= 1'b1;
            BUSY          <= 1'b0;
            DONE          <= 1'b0;
            RESP          <= 8'hFF;
            TIMEOUT       <= 1'b0;
        end else if (ABORT && state != S_IDLE) begin
            // A byte in flight finishes in the engine; the next ISSUE waits on BYTE_BUSY.
            state         <= S_IDLE;
            phase         <= P_ISSUE;
            spi.BYTE_SEND <= 1'b0;
            spi.BYTE_OUT  <= 8'hFF;
            SPI_CS_N      <= 1'b1;
            BUSY          <= 1'b0;
            DONE          <= 1'b0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (START) begin
                        cmd      <= cmd_in;
                        RESP     <= 8'hFF;
                        TIMEOUT  <= 1'b0;
                        SPI_CS_N <= 1'b0;
                        BUSY     <= 1'b1;
                        phase    <= P_ISSUE;
                        byte_cnt <= '0;
                        poll_cnt <= '0;
                        if (PRE_BYTES == 0) begin
                            state        <= S_FRAME;
                            spi.BYTE_OUT <= frame_byte(cmd_in, 3'd0);
                        end else begin
                            state        <= S_PRE;
                            spi.BYTE_OUT <= 8'hFF;
                        end
                    end else if (CS_RELEASE) begin
                        SPI_CS_N <= 1'b1;
                    end
                end
                S_FIN: begin
                    DONE         <= 1'b0;
                    BUSY         <= 1'b0;
                    spi.BYTE_OUT <= 8'hFF;
                    state        <= S_IDLE;
                end
                default: begin
                    case (phase)
                        P_ISSUE: begin
                            if (!spi.BYTE_BUSY) begin
                                spi.BYTE_SEND <= 1'b1;
                                phase         <= P_ARM;
                            end
                        end
                        P_ARM: begin
                            spi.BYTE_SEND <= 1'b0;
                            phase         <= P_WAIT;
                        end
                        P_WAIT: begin
                            if (!spi.BYTE_BUSY) begin
                                phase <= P_ISSUE;
                                case (state)
                                    S_PRE: begin
                                        if (byte_cnt >= PRE_LAST) begin
                                            state        <= S_FRAME;
                                            byte_cnt     <= '0;
                                            spi.BYTE_OUT <= frame_byte(cmd, 3'd0);
                                        end else if (byte_cnt != 3'd7) begin
                                            byte_cnt <= byte_cnt + 3'd1;
                                        end
                                    end
                                    S_FRAME: begin
                                        if (byte_cnt >= 3'd5) begin
                                            state        <= S_POLL;
                                            spi.BYTE_OUT <= 8'hFF;
                                        end else begin
                                            byte_cnt     <= byte_cnt + 3'd1;
                                            spi.BYTE_OUT <= frame_byte(cmd, byte_cnt + 3'd1);
                                        end
                                    end
                                    S_POLL: begin
                                        // CS for FIN is settled here so it is already correct while DONE is high.
                                        if (!spi.BYTE_IN[7]) begin
                                            RESP     <= spi.BYTE_IN;
                                            SPI_CS_N <= !cmd.keep_cs;
                                            DONE     <= 1'b1;
                                            state    <= S_FIN;
                                        end else if (poll_cnt >= POLL_LAST) begin
                                            TIMEOUT  <= 1'b1;
                                            SPI_CS_N <= 1'b1;
                                            DONE     <= 1'b1;
                                            state    <= S_FIN;
                                        end else if (poll_cnt != 8'hFF) begin
                                            poll_cnt <= poll_cnt + 8'd1;
                                        end
                                    end
                                    default: ;
                                endcase
                            end
                        end
                        default: phase <= P_ISSUE;
                    endcase
                end
            endcase
        end
    end
endmodule
